bcd_seg_display: RTL

Display back-end that consumes the 8-bit count from the up-counter stage and drives a 3-digit multiplexed seven-segment display. It converts the binary count to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It then time-multiplexes the three digits, ones/tens/hundreds, onto a shared segment bus. It sits directly downstream of the counter, and its `value` input connects straight to the counter's `state` output.

---
 rtl/bcd_seg_display_pkg.sv | 24 ++
 rtl/bcd_seg_display_if.sv | 15 +
 rtl/bcd_seg_display_seg7_decoder.sv | 26 ++
 rtl/bcd_seg_display.sv | 99 +++++++++
 4 files changed

// File: rtl/bcd_seg_display_pkg.sv
// bcd_seg_display_pkg: shared FSM encoding, digit count, segment patterns and the double-dabble adjust step
package bcd_seg_display_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam int DIGITS = 3;
   // segment patterns, active-high, ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   // add 3 to every nibble >= 5 so the following left shift carries correctly into the next decade
   function automatic logic [11:0] dabble_adj(input logic [11:0] s);
      logic [11:0] r;
      for (int i = 0; i < DIGITS; i++)
         r[4*i +: 4] = s[4*i +: 4] >= 4'd5 ? s[4*i +: 4] + 4'd3 : s[4*i +: 4];
      return r;
   endfunction
endpackage

// File: rtl/bcd_seg_display_if.sv
// bcd_seg_display_if: display back-end bus
//   value     : binary count in (from the counter)
//   bcd       : last converted {hundreds, tens, ones}
//   bcd_valid : one-cycle pulse when bcd updates
//   an        : one-hot digit enable, bit0 = ones
//   seg       : segment drive {g,f,e,d,c,b,a}
interface bcd_seg_display_if;
   logic [7:0]  value;
   logic [11:0] bcd;
   logic        bcd_valid;
   logic [2:0]  an;
   logic [6:0]  seg;
   modport master (output value, input bcd, bcd_valid, an, seg);
   modport slave (input value, output bcd, bcd_valid, an, seg);
endinterface

// File: rtl/bcd_seg_display_seg7_decoder.sv
// seg7_decoder: combinational BCD nibble to seven-segment pattern
//   nib : 4-bit digit in, 10..15 decode to all segments off
//   seg : pattern {g,f,e,d,c,b,a}, active-high
module seg7_decoder
   import bcd_seg_display_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   always_comb begin
      seg = SEG_BLANK;
      case (nib)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end
endmodule

// File: rtl/bcd_seg_display.sv
// bcd_seg_display: serial double-dabble binary-to-BCD plus 3-digit multiplexed seven-segment scan
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-low
//   io  : bcd_seg_display_if.slave (value in; bcd, bcd_valid, an, seg out)
//   SCAN_DIV : cycles each digit is held, 1..256
//   LEADING_ZERO_BLANK_EN : when defined, blanks leading zero hundreds/tens digits
module bcd_seg_display
   import bcd_seg_display_pkg::*;
#(
   parameter int SCAN_DIV = 4
)(
   input logic              clk,
   input logic              rst,
   bcd_seg_display_if.slave io
);
   state_t      state, state_nx;
   logic        capture, step, finish;
   logic [7:0]  last, sr;
   logic [11:0] scr, bcd_q;
   logic [2:0]  cnt;
   logic        valid_q;
   logic [7:0]  div;
   logic [1:0]  idx;
   logic        wrap;
   logic [3:0]  nib;
   logic [6:0]  seg_d, seg_n, seg_q;
   logic [2:0]  an_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      capture = 1'b0;
      step = 1'b0;
      finish = 1'b0;
      case (state)
         IDLE: if (io.value != last) begin
            capture = 1'b1;
            state_nx = SHIFT;
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt == 3'd7) state_nx = DONE;
         end
         DONE: begin
            finish = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   // last only moves on capture, so a value change during a conversion is picked up in the next IDLE
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         last <= '0;
         sr <= '0;
         scr <= '0;
         cnt <= '0;
         bcd_q <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= finish;
         if (capture) begin
            last <= io.value;
            sr <= io.value;
            scr <= '0;
            cnt <= '0;
         end
         if (step) begin
            {scr, sr} <= {dabble_adj(scr), sr} << 1;
            cnt <= cnt + 3'd1;
         end
         if (finish) bcd_q <= scr;
      end
   assign wrap = div == 8'(SCAN_DIV - 1);
   assign nib = idx == 2'd2 ? bcd_q[11:8] : idx == 2'd1 ? bcd_q[7:4] : bcd_q[3:0];
   seg7_decoder u_dec (.nib(nib), .seg(seg_d));
`ifdef LEADING_ZERO_BLANK_EN
   assign seg_n = (idx == 2'd2 && bcd_q[11:8] == 4'd0) || (idx == 2'd1 && bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg_d;
`else
   assign seg_n = seg_d;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         div <= '0;
         idx <= '0;
         an_q <= 3'b001;
         seg_q <= SEG_0;
      end else begin
         div <= wrap ? 8'd0 : div + 8'd1;
         if (wrap) idx <= idx == 2'(DIGITS - 1) ? 2'd0 : idx + 2'd1;
         an_q <= 3'b001 << idx;
         seg_q <= seg_n;
      end
   assign io.bcd = bcd_q;
   assign io.bcd_valid = valid_q;
   assign io.an = an_q;
   assign io.seg = seg_q;
endmodule
